seq_detect_param: RTL and testbench

- Parametrised serial pattern detector. Successor to the fixed 7-bit flag detector (0111110).
- Pattern and length are parameters. Adds an input-valid qualifier, a run-time overlap/non-overlap mode, a saturating match counter and a fill/progress indicator.
- Sits on the serial bit stream after the line receiver and feeds frame-delimit logic.

---
 rtl/seq_detect_param_if.sv | 25 ++
 rtl/seq_detect_param.sv | 83 ++++++++
 tb/tb_seq_detect_param.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Bus between the serial line receiver side and the pattern detector.
// The master drives the qualified bit stream and control; the slave
// (the detector) returns the match pulse, counter and fill level.
interface seq_detect_param_if #(
  parameter int CNT_W  = 8,
  parameter int FILL_W = 3
);
  logic              en;
  logic              inp;
  logic              overlap;
  logic              clr_cnt;
  logic              w;
  logic [CNT_W-1:0]  match_cnt;
  logic [FILL_W-1:0] fill;

  modport master (
    output en, inp, overlap, clr_cnt,
    input  w, match_cnt, fill
  );

  modport slave (
    input  en, inp, overlap, clr_cnt,
    output w, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector. A PAT_LEN-bit shift history plus a
// fill level (bits collected toward a match) form the whole state. A match
// gives a registered one-cycle pulse on w and bumps a saturating counter.
// Overlap mode decides whether the matched bits may seed the next match.
module seq_detect_param #(
  parameter int PAT_LEN = 7,
  parameter     PATTERN = 7'b0111110,
  parameter int CNT_W   = 8,
  parameter int FILL_W  = $clog2(PAT_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);

  // Elaboration guards: bad length or a pattern literal of the wrong width.
  if (PAT_LEN < 2 || PAT_LEN > 32) begin : g_bad_len
    $fatal(1, "seq_detect_param: PAT_LEN must be in 2..32");
  end
  if ($bits(PATTERN) != PAT_LEN) begin : g_bad_pat
    $fatal(1, "seq_detect_param: PATTERN width must equal PAT_LEN");
  end

  localparam logic [PAT_LEN-1:0] PAT      = PAT_LEN'(PATTERN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  logic [PAT_LEN-1:0] hist_q, hist_n, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_n, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               w_q;
  logic               hit;

  // Next history/fill, match detection, retention policy and counter update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    hist_n = hist_q;
    fill_n = fill_q;
    if (bus.en) begin
      hist_n = {hist_q[PAT_LEN-2:0], bus.inp};
      fill_n = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
    end

    hit = bus.en && (fill_n == FILL_MAX) && (hist_n == PAT);

    // Without overlap a match consumes its bits; the next one starts fresh.
    hist_d = hist_n;
    fill_d = fill_n;
    if (hit && !bus.overlap) begin
      hist_d = '0;
      fill_d = '0;
    end

    // Clear wins over the old value but still counts a same-edge match.
    cnt_d = cnt_q;
    if (bus.clr_cnt) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and output registers; reset drops any partial history at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      w_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      w_q    <= hit;
    end
  end

  assign bus.w         = w_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a default 7-bit flag detector and a 3-bit
// 101 detector with a 2-bit counter. Each driven cycle pushes the model's
// expected outputs to a scoreboard queue; they are popped and compared
// once the DUT has registered that edge.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param_if #(.CNT_W(8), .FILL_W(3)) bus_a ();
  seq_detect_param_if #(.CNT_W(2), .FILL_W(2)) bus_b ();

  seq_detect_param dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_detect_param #(
    .PAT_LEN (3),
    .PATTERN (3'b101),
    .CNT_W   (2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct packed {
    logic       w;
    logic [7:0] cnt;
    logic [7:0] fill;
  } obs_t;

  obs_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          sel    = 0;   // 0 = dut_a, 1 = dut_b
  int          pulses = 0;
  logic [31:0] m_bits = '0;
  int          m_fill = 0;
  int          m_cnt  = 0;

  function automatic obs_t observe();
    obs_t o;
    if (sel == 0) begin
      o.w = bus_a.w; o.cnt = bus_a.match_cnt; o.fill = 8'(bus_a.fill);
    end else begin
      o.w = bus_b.w; o.cnt = 8'(bus_b.match_cnt); o.fill = 8'(bus_b.fill);
    end
    return o;
  endfunction

  task automatic model_clear();
    m_bits = '0;
    m_fill = 0;
    m_cnt  = 0;
    pulses = 0;
    sb_q.delete();
  endtask

  // One clock of stimulus on the selected DUT, with scoreboard check.
  task automatic step(input logic en, input logic b, input logic ovl, input logic clr);
    obs_t        exp, got;
    logic        hit;
    int          plen, cmax;
    logic [31:0] pat, mask;
    plen = (sel == 0) ? 7 : 3;
    pat  = (sel == 0) ? 32'h3E : 32'h5;
    cmax = (sel == 0) ? 255 : 3;
    mask = (32'h1 << plen) - 32'h1;

    if (sel == 0) begin
      bus_a.en = en; bus_a.inp = b; bus_a.overlap = ovl; bus_a.clr_cnt = clr;
      bus_b.en = 1'b0; bus_b.clr_cnt = 1'b0;
    end else begin
      bus_b.en = en; bus_b.inp = b; bus_b.overlap = ovl; bus_b.clr_cnt = clr;
      bus_a.en = 1'b0; bus_a.clr_cnt = 1'b0;
    end

    if (en) begin
      m_bits = {m_bits[30:0], b};
      if (m_fill < plen) m_fill++;
    end
    hit = en && (m_fill == plen) && ((m_bits & mask) == pat);
    if (hit && !ovl) begin
      m_bits = '0;
      m_fill = 0;
    end
    if (clr) m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < cmax) m_cnt++;
    exp.w = hit; exp.cnt = 8'(m_cnt); exp.fill = 8'(m_fill);
    sb_q.push_back(exp);

    @(posedge clk);
    #1;
    got = observe();
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got output with no expected entry");
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL step (dut %0d, t=%0t): got w=%b cnt=%0d fill=%0d, expected w=%b cnt=%0d fill=%0d",
                 sel, $time, got.w, got.cnt, got.fill, exp.w, exp.cnt, exp.fill);
      end
    end
    if (got.w === 1'b1) pulses++;
  endtask

  task automatic feed(input string bits, input logic ovl);
    for (int i = 0; i < bits.len(); i++) step(1'b1, bits[i] == 8'h31, ovl, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    // rst is low from time 0; hold it across an edge with valid ones.
    bus_a.en = 1'b1; bus_a.inp = 1'b1; bus_a.overlap = 1'b1; bus_a.clr_cnt = 1'b0;
    bus_b.en = 1'b1; bus_b.inp = 1'b1; bus_b.overlap = 1'b1; bus_b.clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d;
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_state dut %0d: got w=%b cnt=%0d fill=%0d, expected all 0", d, o.w, o.cnt, o.fill);
      end
    end
    sel = 0;
    bus_a.en = 1'b0; bus_b.en = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_match();
    sel = 0;
    do_reset();
    feed("0111110", 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (pulses != 1 || bus_a.match_cnt !== 8'd1 || bus_a.fill !== 3'd7) begin
      errors++;
      $display("FAIL single_match: got pulses=%0d cnt=%0d fill=%0d, expected 1 1 7", pulses, bus_a.match_cnt, bus_a.fill);
    end
  endtask

  task automatic test_overlap();
    sel = 0;
    do_reset();
    feed("0111110111110", 1'b1);
    checks++;
    if (pulses != 2 || bus_a.match_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overlap: got pulses=%0d cnt=%0d, expected 2 2", pulses, bus_a.match_cnt);
    end
  endtask

  task automatic test_non_overlap();
    sel = 0;
    do_reset();
    feed("0111110111110", 1'b0);
    checks++;
    if (pulses != 1 || bus_a.match_cnt !== 8'd1 || bus_a.fill !== 3'd6) begin
      errors++;
      $display("FAIL non_overlap: got pulses=%0d cnt=%0d fill=%0d, expected 1 1 6", pulses, bus_a.match_cnt, bus_a.fill);
    end
  endtask

  task automatic test_gaps();
    string pat;
    pat = "0111110";
    sel = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, pat[i] == 8'h31, 1'b1, 1'b0);
      if (i < 6) begin
        step(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
        step(1'b0, 1'($urandom_range(1)), 1'b1, 1'b0);
      end
    end
    checks++;
    if (pulses != 1 || bus_a.match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL gaps: got pulses=%0d cnt=%0d, expected 1 1", pulses, bus_a.match_cnt);
    end
  endtask

  task automatic test_mid_reset();
    sel = 0;
    do_reset();
    feed("01111", 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus_a.w !== 1'b0 || bus_a.fill !== 3'd0 || bus_a.match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got w=%b cnt=%0d fill=%0d, expected 0 0 0", bus_a.w, bus_a.match_cnt, bus_a.fill);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    feed("10", 1'b1);
    checks++;
    if (pulses != 0 || bus_a.fill !== 3'd2) begin
      errors++;
      $display("FAIL after_reset: got pulses=%0d fill=%0d, expected 0 2", pulses, bus_a.fill);
    end
  endtask

  task automatic test_short_saturate();
    sel = 1;
    do_reset();
    feed("1010101010101", 1'b1);
    checks++;
    if (pulses != 6 || bus_b.match_cnt !== 2'd3) begin
      errors++;
      $display("FAIL saturate: got pulses=%0d cnt=%0d, expected 6 3", pulses, bus_b.match_cnt);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus_b.match_cnt !== 2'd0 || bus_b.w !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_hit: got cnt=%0d w=%b, expected 0 0", bus_b.match_cnt, bus_b.w);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus_b.match_cnt !== 2'd1 || bus_b.w !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_hit: got cnt=%0d w=%b, expected 1 1", bus_b.match_cnt, bus_b.w);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus_b.match_cnt !== 2'd0 || bus_b.w !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: got cnt=%0d w=%b, expected 0 0", bus_b.match_cnt, bus_b.w);
    end
  endtask

  initial begin
    bus_a.en = 1'b0; bus_a.inp = 1'b0; bus_a.overlap = 1'b1; bus_a.clr_cnt = 1'b0;
    bus_b.en = 1'b0; bus_b.inp = 1'b0; bus_b.overlap = 1'b1; bus_b.clr_cnt = 1'b0;
    test_reset();
    test_single_match();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_mid_reset();
    test_short_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
